// File: rtl/row_cache_ctrl.sv
// Fully associative row-tag cache controller.
// Maps a requested RowId to one of 2**CWIDTH row-buffer slots. Each slot keeps a
// tag plus valid and dirty bits. A miss writes back a dirty victim (MemWR) and
// fills the requested row (MemRD) through a level/acknowledge handshake with the
// backing memory. MemOK is an acknowledge only while a request is outstanding.
// Optional feature macro: ROWCACHE_STATS_EN adds saturating hit/miss/writeback
// counters (hit_cnt, miss_cnt, wb_cnt). With it undefined those ports do not exist.
module row_cache_ctrl #(
  parameter int unsigned ADDRWIDTH = 17,
  parameter int unsigned CWIDTH    = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 RD,
  input  logic                 WR,
  input  logic [ADDRWIDTH-1:0] RowId,
  input  logic                 MemOK,
  output logic                 hold,
  output logic                 done,
  output logic                 hit,
  output logic [CWIDTH-1:0]    cRowId,
  output logic                 MemRD,
  output logic                 MemWR,
  output logic [ADDRWIDTH-1:0] MemRowId
`ifdef ROWCACHE_STATS_EN
  ,
  output logic [31:0]          hit_cnt,
  output logic [31:0]          miss_cnt,
  output logic [31:0]          wb_cnt
`endif
);

  localparam int unsigned NSLOTS = 1 << CWIDTH;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_TAG   = 3'd1,
    S_EVICT = 3'd2,
    S_FILL  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                 state_q;
  logic [ADDRWIDTH-1:0]   row_q;
  logic                   is_write_q;
  logic [CWIDTH-1:0]      victim_q;
  logic [CWIDTH-1:0]      rr_q;
  logic [NSLOTS-1:0]      valid_q;
  logic [NSLOTS-1:0]      dirty_q;
  logic [ADDRWIDTH-1:0]   tag_q [NSLOTS];

  logic                   hold_q;
  logic                   done_q;
  logic                   hit_q;
  logic [CWIDTH-1:0]      crow_q;
  logic                   memrd_q;
  logic                   memwr_q;
  logic [ADDRWIDTH-1:0]   memrow_q;

  logic                   req_c;
  logic                   hit_any_c;
  logic [CWIDTH-1:0]      hit_idx_c;
  logic                   free_any_c;
  logic [CWIDTH-1:0]      free_idx_c;
  logic [CWIDTH-1:0]      victim_c;
  logic                   victim_dirty_c;
  logic                   fill_done_c;
  logic                   evict_done_c;

  assign req_c        = RD | WR;
  assign fill_done_c  = (state_q == S_FILL) && MemOK;
  assign evict_done_c = (state_q == S_EVICT) && MemOK;

  // Parallel tag compare of the latched row against every valid slot
  always_comb begin
    hit_any_c = 1'b0;
    hit_idx_c = '0;
    for (int i = 0; i < int'(NSLOTS); i++) begin
      if (valid_q[i] && (tag_q[i] == row_q)) begin
        hit_any_c = 1'b1;
        hit_idx_c = CWIDTH'(i);
      end
    end
  end

  // Lowest-index invalid slot; descending scan so the smallest index wins
  always_comb begin
    free_any_c = 1'b0;
    free_idx_c = '0;
    for (int i = int'(NSLOTS) - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        free_any_c = 1'b1;
        free_idx_c = CWIDTH'(i);
      end
    end
  end

  // Victim: a free slot if any, otherwise the round-robin slot
  always_comb begin
    victim_c       = free_any_c ? free_idx_c : rr_q;
    victim_dirty_c = valid_q[victim_c] && dirty_q[victim_c];
  end

  // Tag storage is written only when a fill completes; no reset needed since valid gates it
  always_ff @(posedge clk) begin
    if (fill_done_c) begin
      tag_q[victim_q] <= row_q;
    end
  end

  // Controller FSM with registered outputs and per-slot valid/dirty state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      row_q      <= '0;
      is_write_q <= 1'b0;
      victim_q   <= '0;
      rr_q       <= '0;
      valid_q    <= '0;
      dirty_q    <= '0;
      hold_q     <= 1'b0;
      done_q     <= 1'b0;
      hit_q      <= 1'b0;
      crow_q     <= '0;
      memrd_q    <= 1'b0;
      memwr_q    <= 1'b0;
      memrow_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (req_c) begin
            // RD and WR together is treated as a write
            row_q      <= RowId;
            is_write_q <= WR;
            hold_q     <= 1'b1;
            state_q    <= S_TAG;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_TAG: begin
          if (hit_any_c) begin
            if (is_write_q) begin
              dirty_q[hit_idx_c] <= 1'b1;
            end
            hit_q   <= 1'b1;
            crow_q  <= hit_idx_c;
            done_q  <= 1'b1;
            hold_q  <= 1'b0;
            state_q <= S_DONE;
          end else begin
            victim_q <= victim_c;
            // Round-robin only moves when every slot was valid
            if (!free_any_c) begin
              rr_q <= rr_q + CWIDTH'(1);
            end
            if (victim_dirty_c) begin
              memwr_q  <= 1'b1;
              memrow_q <= tag_q[victim_c];
              state_q  <= S_EVICT;
            end else begin
              memrd_q  <= 1'b1;
              memrow_q <= row_q;
              state_q  <= S_FILL;
            end
          end
        end
        S_EVICT: begin
          if (MemOK) begin
            memwr_q  <= 1'b0;
            memrd_q  <= 1'b1;
            memrow_q <= row_q;
            state_q  <= S_FILL;
          end
        end
        S_FILL: begin
          if (MemOK) begin
            memrd_q           <= 1'b0;
            valid_q[victim_q] <= 1'b1;
            dirty_q[victim_q] <= is_write_q;
            hit_q             <= 1'b0;
            crow_q            <= victim_q;
            done_q            <= 1'b1;
            hold_q            <= 1'b0;
            state_q           <= S_DONE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign hold     = hold_q;
  assign done     = done_q;
  assign hit      = hit_q;
  assign cRowId   = crow_q;
  assign MemRD    = memrd_q;
  assign MemWR    = memwr_q;
  assign MemRowId = memrow_q;

`ifdef ROWCACHE_STATS_EN
  logic [31:0] hit_cnt_q;
  logic [31:0] miss_cnt_q;
  logic [31:0] wb_cnt_q;

  // Saturating event counters sampled at the edges that complete each event
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      wb_cnt_q   <= '0;
    end else begin
      if ((state_q == S_TAG) && hit_any_c && (hit_cnt_q != 32'hFFFF_FFFF)) begin
        hit_cnt_q <= hit_cnt_q + 32'd1;
      end
      if (fill_done_c && (miss_cnt_q != 32'hFFFF_FFFF)) begin
        miss_cnt_q <= miss_cnt_q + 32'd1;
      end
      if (evict_done_c && (wb_cnt_q != 32'hFFFF_FFFF)) begin
        wb_cnt_q <= wb_cnt_q + 32'd1;
      end
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
  assign wb_cnt   = wb_cnt_q;
`else
  logic unused_evict_done;
  assign unused_evict_done = evict_done_c;
`endif

endmodule

// File: tb/tb_row_cache_ctrl.sv
// Directed bench for row_cache_ctrl: cold miss, hit, full-cache dirty and clean
// eviction, back-to-back hits, MemOK stall, reset during fill, RD+WR dirty marking.
module tb_row_cache_ctrl;

  localparam int AW = 17;
  localparam int CW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          RD;
  logic          WR;
  logic [AW-1:0] RowId;
  logic          MemOK;
  logic          hold;
  logic          done;
  logic          hit;
  logic [CW-1:0] cRowId;
  logic          MemRD;
  logic          MemWR;
  logic [AW-1:0] MemRowId;
`ifdef ROWCACHE_STATS_EN
  logic [31:0]   hit_cnt;
  logic [31:0]   miss_cnt;
  logic [31:0]   wb_cnt;
`endif

  int checks = 0;
  int errors = 0;

  row_cache_ctrl #(.ADDRWIDTH(AW), .CWIDTH(CW)) dut (
    .clk      (clk),
    .rst      (rst),
    .RD       (RD),
    .WR       (WR),
    .RowId    (RowId),
    .MemOK    (MemOK),
    .hold     (hold),
    .done     (done),
    .hit      (hit),
    .cRowId   (cRowId),
    .MemRD    (MemRD),
    .MemWR    (MemWR),
    .MemRowId (MemRowId)
`ifdef ROWCACHE_STATS_EN
    ,
    .hit_cnt  (hit_cnt),
    .miss_cnt (miss_cnt),
    .wb_cnt   (wb_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Advance one cycle; inputs are driven and outputs sampled 1ns after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one request and service memory with immediate MemOK until done
  task automatic req(input logic [AW-1:0] row, input logic rd, input logic wr,
                     output logic o_hit, output logic [CW-1:0] o_slot, output int o_lat,
                     output logic o_wb, output logic [AW-1:0] o_wb_row,
                     output logic o_fill, output logic [AW-1:0] o_fill_row,
                     output logic o_both);
    logic got;
    o_hit = 1'b0; o_slot = '0; o_lat = 0; o_wb = 1'b0; o_wb_row = '0;
    o_fill = 1'b0; o_fill_row = '0; o_both = 1'b0; got = 1'b0;
    RD = rd; WR = wr; RowId = row;
    step();
    RD = 1'b0; WR = 1'b0;
    for (int c = 0; c < 40 && !got; c++) begin
      if (done) begin
        got = 1'b1; o_hit = hit; o_slot = cRowId; MemOK = 1'b0;
      end else begin
        if (MemWR) begin o_wb = 1'b1; o_wb_row = MemRowId; end
        if (MemRD) begin o_fill = 1'b1; o_fill_row = MemRowId; end
        if (MemRD && MemWR) o_both = 1'b1;
        MemOK = MemRD | MemWR;
        step();
        o_lat++;
      end
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL req_timeout row=%0d got no done, want done within 40 cycles", row);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; RD = 1'b0; WR = 1'b0; MemOK = 1'b0; RowId = '0;
    repeat (3) step();
    checks++;
    if ({hold, done, hit, MemRD, MemWR} !== 5'b0) begin
      errors++; $display("FAIL reset_flags got %b want 00000", {hold, done, hit, MemRD, MemWR});
    end
    checks++;
    if (cRowId !== '0) begin errors++; $display("FAIL reset_crow got %0d want 0", cRowId); end
    checks++;
    if (MemRowId !== '0) begin errors++; $display("FAIL reset_memrow got %0d want 0", MemRowId); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_cold_miss();
    WR = 1'b1; RowId = AW'(150);
    step();
    WR = 1'b0;
    checks++;
    if ({hold, MemRD, MemWR, done} !== 4'b1000) begin
      errors++; $display("FAIL cold_tag got hold/rd/wr/done=%b want 1000", {hold, MemRD, MemWR, done});
    end
    step();
    checks++;
    if ({hold, MemRD, MemWR, done} !== 4'b1100) begin
      errors++; $display("FAIL cold_fill got hold/rd/wr/done=%b want 1100", {hold, MemRD, MemWR, done});
    end
    checks++;
    if (MemRowId !== AW'(150)) begin errors++; $display("FAIL cold_memrow got %0d want 150", MemRowId); end
    MemOK = 1'b1;
    step();
    MemOK = 1'b0;
    checks++;
    if ({done, hit, hold, MemRD} !== 4'b1000) begin
      errors++; $display("FAIL cold_done got done/hit/hold/rd=%b want 1000", {done, hit, hold, MemRD});
    end
    checks++;
    if (cRowId !== CW'(0)) begin errors++; $display("FAIL cold_slot got %0d want 0", cRowId); end
    step();
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL cold_pulse got done=%b want 0", done); end
  endtask

  task automatic test_hit();
    logic h, wb, fl, both; logic [CW-1:0] s; logic [AW-1:0] wr_row, fr; int lat;
    req(AW'(150), 1'b1, 1'b0, h, s, lat, wb, wr_row, fl, fr, both);
    checks++;
    if (h !== 1'b1 || s !== CW'(0)) begin
      errors++; $display("FAIL hit_result got hit=%b slot=%0d want hit=1 slot=0", h, s);
    end
    checks++;
    if (lat !== 1 || wb !== 1'b0 || fl !== 1'b0) begin
      errors++; $display("FAIL hit_timing got lat=%0d wr=%b rd=%b want lat=1 wr=0 rd=0", lat, wb, fl);
    end
  endtask

  task automatic test_fill_cache(input int base);
    logic h, wb, fl, both; logic [CW-1:0] s; logic [AW-1:0] wr_row, fr; int lat;
    for (int i = 0; i < 31; i++) begin
      req(AW'(base + i), 1'b1, 1'b0, h, s, lat, wb, wr_row, fl, fr, both);
      checks++;
      if (h !== 1'b0 || s !== CW'(i + 1) || fr !== AW'(base + i) || lat !== 2 || wb !== 1'b0) begin
        errors++;
        $display("FAIL fill_row%0d got hit=%b slot=%0d fill=%0d lat=%0d wb=%b want hit=0 slot=%0d fill=%0d lat=2 wb=0",
                 base + i, h, s, fr, lat, wb, i + 1, base + i);
      end
    end
  endtask

  task automatic test_dirty_evict();
    logic h, wb, fl, both; logic [CW-1:0] s; logic [AW-1:0] wr_row, fr; int lat;
    req(AW'(1000), 1'b1, 1'b0, h, s, lat, wb, wr_row, fl, fr, both);
    checks++;
    if (wb !== 1'b1 || wr_row !== AW'(150)) begin
      errors++; $display("FAIL evict_wb got wr=%b row=%0d want wr=1 row=150", wb, wr_row);
    end
    checks++;
    if (fl !== 1'b1 || fr !== AW'(1000) || both !== 1'b0) begin
      errors++; $display("FAIL evict_fill got rd=%b row=%0d both=%b want rd=1 row=1000 both=0", fl, fr, both);
    end
    checks++;
    if (h !== 1'b0 || s !== CW'(0) || lat !== 3) begin
      errors++; $display("FAIL evict_done got hit=%b slot=%0d lat=%0d want hit=0 slot=0 lat=3", h, s, lat);
    end
  endtask

  task automatic test_clean_evict();
    logic h, wb, fl, both; logic [CW-1:0] s; logic [AW-1:0] wr_row, fr; int lat;
    req(AW'(2000), 1'b1, 1'b0, h, s, lat, wb, wr_row, fl, fr, both);
    checks++;
    if (wb !== 1'b0 || fr !== AW'(2000) || h !== 1'b0 || s !== CW'(1) || lat !== 2) begin
      errors++;
      $display("FAIL clean_evict got wb=%b fill=%0d hit=%b slot=%0d lat=%0d want wb=0 fill=2000 hit=0 slot=1 lat=2",
               wb, fr, h, s, lat);
    end
  endtask

  task automatic test_back_to_back();
    logic h, wb, fl, both; logic [CW-1:0] s; logic [AW-1:0] wr_row, fr; int lat;
    req(AW'(1000), 1'b1, 1'b0, h, s, lat, wb, wr_row, fl, fr, both);
    checks++;
    if (h !== 1'b1 || s !== CW'(0) || lat !== 1) begin
      errors++; $display("FAIL b2b_first got hit=%b slot=%0d lat=%0d want 1/0/1", h, s, lat);
    end
    req(AW'(2000), 1'b1, 1'b0, h, s, lat, wb, wr_row, fl, fr, both);
    checks++;
    if (h !== 1'b1 || s !== CW'(1) || lat !== 1) begin
      errors++; $display("FAIL b2b_second got hit=%b slot=%0d lat=%0d want 1/1/1", h, s, lat);
    end
  endtask

  task automatic test_stall();
    RD = 1'b1; RowId = AW'(3000);
    step();
    RD = 1'b0;
    step();
    checks++;
    if (MemRD !== 1'b1 || MemRowId !== AW'(3000)) begin
      errors++; $display("FAIL stall_fill got rd=%b row=%0d want rd=1 row=3000", MemRD, MemRowId);
    end
    MemOK = 1'b0;
    for (int c = 0; c < 10; c++) begin
      RD = (c == 3);
      RowId = (c == 3) ? AW'(150) : AW'(3000);
      step();
      checks++;
      if ({MemRD, hold, done} !== 3'b110) begin
        errors++; $display("FAIL stall_cycle%0d got rd/hold/done=%b want 110", c, {MemRD, hold, done});
      end
    end
    RD = 1'b0;
    MemOK = 1'b1;
    step();
    MemOK = 1'b0;
    checks++;
    if (done !== 1'b1 || hit !== 1'b0 || cRowId !== CW'(2)) begin
      errors++; $display("FAIL stall_done got done=%b hit=%b slot=%0d want 1/0/2", done, hit, cRowId);
    end
    step();
    checks++;
    if ({done, hold, MemRD, MemWR} !== 4'b0000) begin
      errors++; $display("FAIL stall_after got done/hold/rd/wr=%b want 0000", {done, hold, MemRD, MemWR});
    end
  endtask

  task automatic test_reset_mid_fill();
    logic h, wb, fl, both; logic [CW-1:0] s; logic [AW-1:0] wr_row, fr; int lat;
    RD = 1'b1; RowId = AW'(4000);
    step();
    RD = 1'b0;
    step();
    checks++;
    if (MemRD !== 1'b1) begin errors++; $display("FAIL rstfill_pre got rd=%b want 1", MemRD); end
    rst = 1'b1;
    #1;
    checks++;
    if ({hold, done, hit, MemRD, MemWR} !== 5'b0 || cRowId !== '0 || MemRowId !== '0) begin
      errors++;
      $display("FAIL rstfill_async got flags=%b slot=%0d row=%0d want 00000/0/0",
               {hold, done, hit, MemRD, MemWR}, cRowId, MemRowId);
    end
    step();
    step();
    rst = 1'b0;
    step();
    req(AW'(150), 1'b1, 1'b0, h, s, lat, wb, wr_row, fl, fr, both);
    checks++;
    if (h !== 1'b0 || s !== CW'(0) || fr !== AW'(150) || wb !== 1'b0 || lat !== 2) begin
      errors++;
      $display("FAIL rstfill_after got hit=%b slot=%0d fill=%0d wb=%b lat=%0d want 0/0/150/0/2", h, s, fr, wb, lat);
    end
  endtask

  task automatic test_rd_wr_dirty();
    logic h, wb, fl, both; logic [CW-1:0] s; logic [AW-1:0] wr_row, fr; int lat;
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    req(AW'(7), 1'b1, 1'b1, h, s, lat, wb, wr_row, fl, fr, both);
    checks++;
    if (h !== 1'b0 || s !== CW'(0) || fr !== AW'(7)) begin
      errors++; $display("FAIL rdwr_install got hit=%b slot=%0d fill=%0d want 0/0/7", h, s, fr);
    end
    test_fill_cache(300);
    req(AW'(5000), 1'b1, 1'b0, h, s, lat, wb, wr_row, fl, fr, both);
    checks++;
    if (wb !== 1'b1 || wr_row !== AW'(7) || s !== CW'(0) || lat !== 3) begin
      errors++; $display("FAIL rdwr_evict got wb=%b row=%0d slot=%0d lat=%0d want 1/7/0/3", wb, wr_row, s, lat);
    end
    req(AW'(5001), 1'b1, 1'b0, h, s, lat, wb, wr_row, fl, fr, both);
    checks++;
    if (wb !== 1'b0 || s !== CW'(1) || fr !== AW'(5001)) begin
      errors++; $display("FAIL rr_advance got wb=%b slot=%0d fill=%0d want 0/1/5001", wb, s, fr);
    end
`ifdef ROWCACHE_STATS_EN
    checks++;
    if (hit_cnt !== 32'd0 || miss_cnt !== 32'd34 || wb_cnt !== 32'd1) begin
      errors++; $display("FAIL stats got hit=%0d miss=%0d wb=%0d want 0/34/1", hit_cnt, miss_cnt, wb_cnt);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_hit();
    test_fill_cache(200);
    test_dirty_evict();
    test_clean_evict();
    test_back_to_back();
    test_stall();
    test_reset_mid_fill();
    test_rd_wr_dirty();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got no completion want finish before 200us");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/row_cache_ctrl.md
Name: row_cache_ctrl

Overview:
Parametrised, fully associative row-tag cache controller for the DRAM emulator. Maps incoming row addresses (RowId) to one of 2**CWIDTH on-chip row-buffer slots (cRowId). Tracks valid and dirty state per slot. On a miss it performs dirty-row writeback and row fill through a MemRD/MemWR/MemOK handshake with backing memory.

Parameters:
ADDRWIDTH, 17, row address width (RowId, MemRowId)
CWIDTH, 5, slot index width; NSLOTS = 2**CWIDTH

Ports:
clk  in  1  clock; all state changes on rising edge
rst  in  1  asynchronous active-high reset
RD  in  1  read request (row access)
WR  in  1  write request; installed/hit slot marked dirty
RowId  in  ADDRWIDTH  requested row
MemOK  in  1  backing memory acknowledges current MemRD/MemWR
hold  out  1  busy; requests ignored while high
done  out  1  one-cycle pulse, result valid
hit  out  1  valid with done; 1 = hit, 0 = miss serviced
cRowId  out  CWIDTH  slot holding the row; valid with done, held until next done
MemRD  out  1  fill request, level, held until MemOK
MemWR  out  1  writeback request, level, held until MemOK
MemRowId  out  ADDRWIDTH  row for MemRD/MemWR

Behaviour:
- Reset (async): state IDLE; all valid/dirty bits 0; RR pointer 0; all outputs 0; any pending request dropped.
- States: IDLE, TAG, EVICT, FILL, DONE. All outputs registered.
- Accept: in IDLE or DONE, at an edge with RD|WR=1. Latch RowId and is_write=WR, then go to TAG. RD&WR together = write.
- hold = 1 in TAG, EVICT and FILL; 0 in IDLE and DONE. Requests in TAG/EVICT/FILL are ignored, not queued.
- TAG (1 cycle): compare the latched RowId against all valid tags.
  - Hit: go to DONE with hit=1 and cRowId = matching slot. If is_write, set dirty.
  - Miss: choose a victim slot.
- Victim choice: the lowest-index invalid slot. If all slots are valid, the RR pointer slot is used, and RR then increments mod NSLOTS. RR advances only on full-cache eviction.
- Miss, victim valid and dirty: go to EVICT.
  - MemWR=1, MemRowId = victim tag.
  - When MemOK is sampled 1 (including on the first EVICT edge): MemWR=0, go to FILL.
- Miss, victim invalid or clean: go directly to FILL.
- FILL:
  - MemRD=1, MemRowId = latched RowId.
  - When MemOK is sampled 1: install tag, valid=1, dirty=is_write; go to DONE with hit=0 and cRowId = victim.
- DONE: done=1 for exactly one cycle. Next state is TAG if a new request is present, else IDLE. Back-to-back throughput: hit every 2 cycles.
- Latency:
  - Hit: done is high in the cycle after the second edge following acceptance.
  - Miss: 2 + (writeback ? 1 : 0) + MemOK wait cycles.
- MemOK sampled outside EVICT/FILL is ignored. MemRD and MemWR are never high together.
- Duplicate tags are impossible: install happens only after a miss.

Optional Feature:
ROWCACHE_STATS_EN:
- Defined: adds outputs hit_cnt[31:0], miss_cnt[31:0] and wb_cnt[31:0].
  - hit_cnt / miss_cnt increment at the DONE entry edge for hits and misses respectively.
  - wb_cnt increments on EVICT completion.
  - All three saturate at 2**32-1 and are reset to 0 by rst.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Cold miss: after reset, WR=1 RowId=150 for one cycle -> hold=1, MemRD=1 MemRowId=150, MemWR=0. Pulse MemOK -> done=1 hit=0 cRowId=0, hold=0.
- Hit: then RD RowId=150 -> done=1 hit=1 cRowId=0 two edges after acceptance; MemRD/MemWR stay 0.
- Full-cache dirty eviction: after case 1, RD rows 200..230 (MemOK immediate) -> slots 1..31.
  - RD 1000 -> MemWR=1 MemRowId=150 first; MemOK; then MemRD=1 MemRowId=1000; MemOK -> done hit=0 cRowId=0.
  - RD 2000 -> clean victim slot 1: no MemWR, MemRD MemRowId=2000, cRowId=1.
- Stall: MemOK held 0 for 10 cycles during FILL -> MemRD and hold stay 1, done stays 0, and an RD presented meanwhile is ignored. Release MemOK -> single done.
- Reset mid-FILL: assert rst while MemRD=1 -> all outputs 0 immediately. After release, RD 150 -> miss, MemRD MemRowId=150, cRowId=0.
- RD and WR together on RowId=7 into an empty cache -> fills slot 0. A later full-cache eviction of slot 0 issues MemWR MemRowId=7 (proves dirty was set).
